// File: rtl/crash_course_cpu_pkg.sv
// Shared definitions for the crash-course CPU IO path.
//   io_arb_state_t : write arbiter FSM states (IDLE, WRITE, LOCKED)
//   IO_DATA_W      : width of one IO byte
package crash_course_cpu_pkg;

    localparam int IO_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        LOCKED = 2'd2
    } io_arb_state_t;

endpackage

// File: rtl/crash_course_rr_pick.sv
// Combinational rotate-priority picker.
// The first asserted request found when scanning upward from `start`
// (wrapping modulo REQUESTERS) wins.
//   req       in  REQUESTERS  request vector
//   start     in  IDW         index scanned first (must be < REQUESTERS)
//   grant     out REQUESTERS  one-hot winner, zero when no request
//   grant_idx out IDW         index of the winner
//   any       out 1           at least one request present
module crash_course_rr_pick #(
    parameter int REQUESTERS = 4,
    parameter int IDW        = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDW-1:0]        start,
    output logic [REQUESTERS-1:0] grant,
    output logic [IDW-1:0]        grant_idx,
    output logic                  any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = int'(start) + k;
            if (idx >= REQUESTERS) begin
                idx = idx - REQUESTERS;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/crash_course_io_arbiter.sv
// Round-robin write arbiter in front of the IO block's single byte port.
// A byte accepted from a requester is held in WRITE until an advance cycle
// (clk_en && system_enabled), which is when the IO block captures it.
// A requester that sets req_lock with its byte keeps ownership (LOCKED)
// so it can emit an uninterrupted multi-byte sequence.
//   clk, async_rst_n        clock, asynchronous active-low reset
//   clk_en, system_enabled  advance qualifiers
//   req_valid/lock/data     per-requester request, lock and byte
//   req_ready               one-hot accept strobe (combinational)
//   io_write_data/enable    registered write port to the IO block
//   grant_id                current or last owner
//   busy                    FSM not in IDLE
module crash_course_io_arbiter
    import crash_course_cpu_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int IDW        = $clog2(REQUESTERS)
) (
    input  logic                            clk,
    input  logic                            async_rst_n,
    input  logic                            clk_en,
    input  logic                            system_enabled,
    input  logic [REQUESTERS-1:0]           req_valid,
    input  logic [REQUESTERS-1:0]           req_lock,
    input  logic [IO_DATA_W*REQUESTERS-1:0] req_data,
    output logic [REQUESTERS-1:0]           req_ready,
    output logic [IO_DATA_W-1:0]            io_write_data,
    output logic                            io_write_enable,
    output logic [IDW-1:0]                  grant_id,
    output logic                            busy
);

    io_arb_state_t          state_q, state_d;
    logic [IO_DATA_W-1:0]   data_q, data_d;
    logic                   lock_q, lock_d;
    logic [IDW-1:0]         last_q, last_d;

    logic                   adv;
    logic [IDW-1:0]         start;
    logic [REQUESTERS-1:0]  pick_grant;
    logic [IDW-1:0]         pick_idx;
    logic                   pick_any;

    assign adv = clk_en && system_enabled;

    // Search begins one past the last owner, wrapping for non-power-of-2 counts.
    assign start = (last_q == IDW'(REQUESTERS - 1)) ? '0 : last_q + 1'b1;

    crash_course_rr_pick #(
        .REQUESTERS (REQUESTERS),
        .IDW        (IDW)
    ) u_pick (
        .req        (req_valid),
        .start      (start),
        .grant      (pick_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        lock_d    = lock_q;
        last_d    = last_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (adv && pick_any) begin
                    req_ready = pick_grant;
                    data_d    = req_data[int'(pick_idx)*IO_DATA_W +: IO_DATA_W];
                    lock_d    = req_lock[pick_idx];
                    last_d    = pick_idx;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // The advance cycle that leaves WRITE is the IO capture cycle.
                if (adv) begin
                    state_d = lock_q ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                if (adv) begin
                    if (req_valid[last_q]) begin
                        req_ready[last_q] = 1'b1;
                        data_d  = req_data[int'(last_q)*IO_DATA_W +: IO_DATA_W];
                        lock_d  = req_lock[last_q];
                        state_d = WRITE;
                    end else if (!req_lock[last_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            lock_q  <= 1'b0;
            last_q  <= IDW'(REQUESTERS - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
        end
    end

    assign io_write_enable = (state_q == WRITE);
    assign io_write_data   = data_q;
    assign grant_id        = last_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_crash_course_io_arbiter.sv
module tb_crash_course_io_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ce, se;
    logic [N-1:0]   valid, lock;
    logic [7:0]     dat [N];
    logic [8*N-1:0] req_data_w;
    logic [N-1:0]   req_ready;
    logic [7:0]     io_write_data;
    logic           io_write_enable;
    logic [1:0]     grant_id;
    logic           busy;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending byte, its owner, and whether ownership is held.
    bit         m_pend;
    logic [7:0] m_byte;
    int         m_owner;
    bit         m_locked;
    bit         m_lf;

    logic [N-1:0] exp_ready, obs_ready;
    logic         obs_we_pre, obs_we, obs_busy;
    logic [7:0]   obs_data;
    logic [1:0]   obs_gid;
    logic [7:0]   dut_wr [$];

    always #5 clk = ~clk;

    always_comb begin
        req_data_w = '0;
        for (int i = 0; i < N; i++) req_data_w[8*i +: 8] = dat[i];
    end

    crash_course_io_arbiter #(.REQUESTERS(N)) dut (
        .clk             (clk),
        .async_rst_n     (rst_n),
        .clk_en          (ce),
        .system_enabled  (se),
        .req_valid       (valid),
        .req_lock        (lock),
        .req_data        (req_data_w),
        .req_ready       (req_ready),
        .io_write_data   (io_write_data),
        .io_write_enable (io_write_enable),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    task automatic model_reset();
        m_pend = 0; m_byte = 8'h00; m_owner = N - 1; m_locked = 0; m_lf = 0;
    endtask

    // One clock: sample combinational outputs at negedge, advance model on posedge.
    task automatic tick();
        bit adv;
        bit found;
        int w;
        @(negedge clk);
        adv = ce && se;
        exp_ready = '0;
        found = 0;
        if (adv && !m_pend) begin
            if (m_locked) begin
                if (valid[m_owner]) exp_ready[m_owner] = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    w = (m_owner + k) % N;
                    if (!found && valid[w]) begin
                        exp_ready[w] = 1'b1;
                        found = 1;
                    end
                end
            end
        end
        obs_ready  = req_ready;
        obs_we_pre = io_write_enable;
        if (io_write_enable && adv) dut_wr.push_back(io_write_data);
        @(posedge clk);
        if (adv) begin
            if (m_pend) begin
                m_pend   = 0;
                m_locked = m_lf;
            end else if (exp_ready != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (exp_ready[i]) begin
                        m_pend = 1; m_byte = dat[i]; m_owner = i; m_lf = lock[i];
                    end
                end
            end else if (m_locked && !valid[m_owner] && !lock[m_owner]) begin
                m_locked = 0;
            end
        end
        #1;
        obs_we   = io_write_enable;
        obs_data = io_write_data;
        obs_gid  = grant_id;
        obs_busy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; se = 1'b1; valid = '0; lock = '0;
        for (int i = 0; i < N; i++) dat[i] = 8'h00;
        model_reset();
        #22;
        total++;
        if (io_write_enable !== 1'b0 || io_write_data !== 8'h00 || grant_id !== 2'd3 ||
            busy !== 1'b0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset: we=%b data=%h gid=%0d busy=%b ready=%b, required 0 00 3 0 0000",
                     io_write_enable, io_write_data, grant_id, busy, req_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        dut_wr.delete();
        valid = 4'b1111; lock = '0;
        for (int i = 0; i < N; i++) dat[i] = 8'h10 + 8'(i);
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (obs_ready !== exp_ready || obs_we !== m_pend || (m_pend && obs_data !== m_byte) ||
                obs_gid !== 2'(m_owner) || obs_busy !== (m_pend || m_locked)) begin
                bad++;
                $display("FAIL rr cycle %0d: ready=%b/%b we=%b/%b data=%h/%h gid=%0d/%0d",
                         c, obs_ready, exp_ready, obs_we, m_pend, obs_data, m_byte, obs_gid, m_owner);
            end
            total++;
            if ((c % 2 == 0) ? ($countones(obs_ready) != 1) : (obs_ready != 4'b0000)) begin
                bad++;
                $display("FAIL rr ready pattern cycle %0d: ready=%b", c, obs_ready);
            end
        end
        valid = '0;
        tick();
        total++;
        if (dut_wr.size() != 5 || dut_wr[0] !== 8'h10 || dut_wr[1] !== 8'h11 ||
            dut_wr[2] !== 8'h12 || dut_wr[3] !== 8'h13 || dut_wr[4] !== 8'h10) begin
            bad++;
            $display("FAIL rr sequence: got %0d bytes %p, required 10 11 12 13 10", dut_wr.size(), dut_wr);
        end
    endtask

    task automatic test_lock();
        int beat = 0;
        dut_wr.delete();
        valid = 4'b0101; lock = 4'b0100;
        dat[0] = 8'h55; dat[2] = 8'hA1;
        for (int c = 0; c < 30 && beat < 3; c++) begin
            tick();
            total++;
            if (obs_ready !== exp_ready || obs_we !== m_pend || obs_busy !== (m_pend || m_locked)) begin
                bad++;
                $display("FAIL lock model cycle %0d: ready=%b/%b we=%b/%b", c, obs_ready, exp_ready, obs_we, m_pend);
            end
            total++;
            if (obs_ready[0] !== 1'b0) begin
                bad++;
                $display("FAIL lock ready0 cycle %0d: ready=%b, required bit0=0", c, obs_ready);
            end
            if (obs_ready[2] === 1'b1) begin
                beat++;
                if (beat == 1) begin dat[2] = 8'hA2; lock[2] = 1'b1; end
                if (beat == 2) begin dat[2] = 8'hA3; lock[2] = 1'b0; end
                if (beat == 3) valid[2] = 1'b0;
            end
        end
        total++;
        if (beat != 3) begin
            bad++;
            $display("FAIL lock beats: got %0d accepted, required 3", beat);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs_ready !== exp_ready || obs_we !== m_pend || obs_gid !== 2'(m_owner)) begin
                bad++;
                $display("FAIL lock tail cycle %0d: ready=%b/%b we=%b/%b gid=%0d/%0d",
                         c, obs_ready, exp_ready, obs_we, m_pend, obs_gid, m_owner);
            end
        end
        valid = '0;
        tick();
        total++;
        if (dut_wr.size() != 4 || dut_wr[0] !== 8'hA1 || dut_wr[1] !== 8'hA2 ||
            dut_wr[2] !== 8'hA3 || dut_wr[3] !== 8'h55) begin
            bad++;
            $display("FAIL lock sequence: got %0d bytes %p, required A1 A2 A3 55", dut_wr.size(), dut_wr);
        end
    endtask

    task automatic test_clk_en();
        int high = 0;
        logic [3:0] pat;
        pat = 4'b1000;
        valid = 4'b0010; lock = '0; dat[1] = 8'h3C;
        tick();
        total++;
        if (obs_ready !== 4'b0010 || obs_we !== 1'b1) begin
            bad++;
            $display("FAIL clk_en accept: ready=%b we=%b, required 0010 1", obs_ready, obs_we);
        end
        for (int c = 0; c < 4; c++) begin
            ce = pat[c];
            tick();
            if (obs_we_pre) high++;
            total++;
            if (obs_ready !== 4'b0000 || obs_ready !== exp_ready) begin
                bad++;
                $display("FAIL clk_en ready cycle %0d: ready=%b, required 0000", c, obs_ready);
            end
        end
        total++;
        if (high != 4 || obs_we !== 1'b0 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL clk_en hold: high=%0d we_after=%b busy=%b, required 4 0 0", high, obs_we, obs_busy);
        end
        valid = '0; ce = 1'b1;
        tick();
    endtask

    task automatic test_sys_en();
        se = 1'b0; valid = 4'b0010; dat[1] = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs_ready !== 4'b0000 || obs_busy !== 1'b0 || obs_ready !== exp_ready) begin
                bad++;
                $display("FAIL sysen off cycle %0d: ready=%b busy=%b, required 0000 0", c, obs_ready, obs_busy);
            end
        end
        se = 1'b1;
        tick();
        total++;
        if (obs_ready !== 4'b0010 || obs_we !== 1'b1 || obs_data !== 8'h5A || obs_gid !== 2'd1) begin
            bad++;
            $display("FAIL sysen on: ready=%b we=%b data=%h gid=%0d, required 0010 1 5a 1",
                     obs_ready, obs_we, obs_data, obs_gid);
        end
        valid = '0;
        tick();
    endtask

    task automatic test_lock_release();
        dut_wr.delete();
        valid = 4'b1001; lock = 4'b1000; dat[3] = 8'h33; dat[0] = 8'h44;
        tick();
        total++;
        if (obs_ready !== 4'b1000) begin
            bad++;
            $display("FAIL release grab: ready=%b, required 1000", obs_ready);
        end
        tick();
        valid[3] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (obs_ready !== 4'b0000 || obs_busy !== 1'b1 || obs_ready !== exp_ready) begin
                bad++;
                $display("FAIL release hold cycle %0d: ready=%b busy=%b, required 0000 1", c, obs_ready, obs_busy);
            end
        end
        lock[3] = 1'b0;
        tick();
        total++;
        if (obs_ready !== 4'b0000 || obs_busy !== 1'b0) begin
            bad++;
            $display("FAIL release drop: ready=%b busy=%b, required 0000 0", obs_ready, obs_busy);
        end
        tick();
        total++;
        if (obs_ready !== 4'b0001 || obs_gid !== 2'd0) begin
            bad++;
            $display("FAIL release next: ready=%b gid=%0d, required 0001 0", obs_ready, obs_gid);
        end
        valid = '0;
        tick();
        tick();
        total++;
        if (dut_wr.size() != 2 || dut_wr[0] !== 8'h33 || dut_wr[1] !== 8'h44) begin
            bad++;
            $display("FAIL release sequence: got %0d bytes %p, required 33 44", dut_wr.size(), dut_wr);
        end
    endtask

    task automatic test_reset_mid();
        valid = 4'b0100; lock = 4'b0100; dat[2] = 8'h7E;
        tick();
        total++;
        if (obs_we !== 1'b1 || obs_data !== 8'h7E) begin
            bad++;
            $display("FAIL rstmid setup: we=%b data=%h, required 1 7e", obs_we, obs_data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (io_write_enable !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd3) begin
            bad++;
            $display("FAIL rstmid: we=%b busy=%b gid=%0d, required 0 0 3", io_write_enable, busy, grant_id);
        end
        model_reset();
        rst_n = 1'b1;
        valid = 4'b1111; lock = '0;
        tick();
        total++;
        if (obs_ready !== 4'b0001 || obs_gid !== 2'd0 || obs_ready !== exp_ready) begin
            bad++;
            $display("FAIL rstmid first grant: ready=%b gid=%0d, required 0001 0", obs_ready, obs_gid);
        end
        valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid = 4'($urandom);
            lock  = 4'($urandom);
            for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
            ce = ($urandom_range(0, 3) != 0);
            se = ($urandom_range(0, 4) != 0);
            tick();
            total++;
            if (obs_ready !== exp_ready || obs_we !== m_pend || (m_pend && obs_data !== m_byte) ||
                obs_gid !== 2'(m_owner) || obs_busy !== (m_pend || m_locked)) begin
                bad++;
                $display("FAIL random cycle %0d: ready=%b/%b we=%b/%b data=%h/%h gid=%0d/%0d busy=%b/%b",
                         c, obs_ready, exp_ready, obs_we, m_pend, obs_data, m_byte,
                         obs_gid, m_owner, obs_busy, (m_pend || m_locked));
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_clk_en();
        test_sys_en();
        test_lock_release();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
